pcileech_cfgshadow_rsp: RTL and testbench
=========================================

// Module: pcileech_cfgshadow_rsp
// PURPOSE
//  Responder side of the shadow config-space read interface used by local consumers (MSI-X controller etc).
//  Holds a 1024 x 32-bit shadow of PCIe config space and answers local DWORD reads at fixed latency.
//  Also accepts host config-write DWORDs from the TLP path and applies them with a per-bit RW writemask (read-modify-write).
//  Sits between the config-TLP handler (write side) and the local readers (read side).
// PARAMETERS
//  ADDR_W       10             DWORD address width (1024 DWORDs = 4 KB config space)
//  DATA_INIT    "cfgspace.coe" initial shadow contents (loaded at configuration, not on rst)
//  MASK_INIT    "cfgspace_writemask.coe"  per-bit writemask; 1 = host-writable
//  MSIX_CAP_DW  10'h10         DWORD address of MSI-X cap header (cap at byte 0x40)
// PORTS
//  clk          in   1        system clock; the only clock
//  rst          in   1        synchronous reset, active-high
//  cfg_rden     in   1        local read strobe, one-cycle pulse
//  cfg_rd_addr  in   ADDR_W   local read DWORD address, sampled with cfg_rden
//  cfg_rd_data  out  32       local read data; held until next read completes
//  cfg_rd_valid out  1        one-cycle pulse, cfg_rd_data updated this cycle
//  wr_valid     in   1        host write request valid
//  wr_ready     out  1        host write accepted when wr_valid & wr_ready
//  wr_addr      in   ADDR_W   host write DWORD address
//  wr_be        in   4        host write byte enables
//  wr_data      in   32       host write data
//  msix_enable  out  1        [CFGSHADOW_MSIX_SNOOP_EN] MsgCtrl bit 15 (DWORD bit 31)
//  msix_fnmask  out  1        [CFGSHADOW_MSIX_SNOOP_EN] MsgCtrl bit 14 (DWORD bit 30)
// BEHAVIOUR
//  Reset: cfg_rd_data=0, cfg_rd_valid=0, wr_ready=0 during rst then 1, msix_*=0; pipelines flushed.
//  Shadow/mask RAM contents are NOT altered by rst; a write not yet committed when rst hits is dropped.
//  Read: cfg_rden sampled high at edge k -> cfg_rd_data/cfg_rd_valid updated at edge k+1 (RAM reg + output reg
//   merged: 1 clock). Back-to-back reads every cycle supported; cfg_rden with no prior read leaves data 0.
//  Write pipeline (3 stages, 1 write/cycle, wr_ready=1 always outside reset):
//   W0 accept: latch addr/be/data, read shadow + mask at addr.
//   W1 merge: m = mask & {{8{be[3]}},..,{8{be[0]}}}; new = (old & ~m) | (wdata & m).
//   W2 commit: write new to shadow at addr.
//  Hazards: W1 old value forwarded from W2 if same address (consecutive writes to same DWORD merge correctly).
//  Read/write collision: local read of an address in W1 or W2 returns the newest merged value (write-first).
//  be=0 or mask=0: commit performed, value unchanged. Addresses wrap naturally within ADDR_W; no out-of-range.
//  Simultaneous cfg_rden and wr_valid: both serviced same cycle (true dual-port RAM).
// CONFIGURATION
//  CFGSHADOW_MSIX_SNOOP_EN defined: msix_enable/msix_fnmask registered from the W2 commit value when
//   W2 addr == MSIX_CAP_DW (update at the commit edge); cleared on rst. Lets consumers skip polling.
//  Undefined: snoop logic absent; msix_enable/msix_fnmask tied 0.
// STRUCTURE
//  pcileech_cfgshadow_pkg: CFG_ADDR_W, MSIX_CAP_DW, MSIX_EN_BIT=31, MSIX_FNMASK_BIT=30, be-to-bitmask function.
//  Sub-module pcileech_cfgshadow_ram: true dual-port 1024x32 BRAM (A = write pipeline rd+wr, B = local read),
//   plus single-port ROM instance for writemask. Forwarding/merge logic stays in top.
// TESTING
//  1 cfg_rden addr 0x000 after init -> cfg_rd_valid next edge, cfg_rd_data = DATA_INIT[0].
//  2 mask[0x10]=0xC0000000, write 0x10 data 0xFFFFFFFF be 0xF -> read 0x10 = old|0xC0000000, low bits unchanged.
//  3 write 0x10 be 0x8 data 0x80000000 then next cycle be 0x8 data 0x40000000 -> final bits[31:30] = 01.
//  4 write 0x20 data 0x12345678 (mask all 1) and cfg_rden 0x20 one cycle later -> read returns 0x12345678.
//  5 rst asserted the cycle after write accept -> write dropped, read 0x20 returns prior value, outputs 0.
//  6 with CFGSHADOW_MSIX_SNOOP_EN: write 0x10 bit31=1 -> msix_enable=1 at commit edge; without: stays 0.

Source files
------------

// File: rtl/pcileech_cfgshadow_pkg.sv
// Shared constants, types and helpers for the config-space shadow responder.
// The power-up images below stand in for cfgspace.coe / cfgspace_writemask.coe
// and are applied at configuration time only (never by rst).
package pcileech_cfgshadow_pkg;

    localparam int CFG_ADDR_W      = 10;
    localparam int CFG_DEPTH       = 1 << CFG_ADDR_W;
    localparam int DATA_W          = 32;

    localparam logic [CFG_ADDR_W-1:0] MSIX_CAP_DW = 10'h010;
    localparam int MSIX_EN_BIT     = 31;
    localparam int MSIX_FNMASK_BIT = 30;

    typedef logic [DATA_W-1:0] cfg_ram_t [0:CFG_DEPTH-1];

    // Shadow contents: ID DWORD, MSI-X cap header (id 0x11, next 0x70,
    // table size 4), a scratch DWORD and a half-writable DWORD.
    localparam cfg_ram_t CFG_DATA_IMG = '{
        0:       32'h0666_10EE,
        16:      32'h0003_7011,
        32:      32'hA5A5_0000,
        48:      32'h1111_2222,
        default: 32'h0000_0000
    };

    // Writemask: 1 = host-writable bit.
    localparam cfg_ram_t CFG_MASK_IMG = '{
        16:      32'hC000_0000,
        32:      32'hFFFF_FFFF,
        48:      32'h0000_FFFF,
        default: 32'h0000_0000
    };

    // Expand 4 byte enables into a 32-bit per-bit lane mask.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [3:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pcileech_cfgshadow_ram.sv
// Shadow storage: dual-port 1024x32 RAM (port A serves the write pipeline's
// read and commit, port B the local reader) plus the writemask ROM, read on
// the same edge as port A. Both reads are registered.
module pcileech_cfgshadow_ram #(
    parameter int ADDR_W = pcileech_cfgshadow_pkg::CFG_ADDR_W,
    parameter pcileech_cfgshadow_pkg::cfg_ram_t DATA_INIT = pcileech_cfgshadow_pkg::CFG_DATA_IMG,
    parameter pcileech_cfgshadow_pkg::cfg_ram_t MASK_INIT = pcileech_cfgshadow_pkg::CFG_MASK_IMG
) (
    input  logic              clk,
    input  logic              a_rd_en,
    input  logic [ADDR_W-1:0] a_rd_addr,
    output logic [31:0]       a_rd_data,
    output logic [31:0]       a_mask,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_wr_addr,
    input  logic [31:0]       a_wr_data,
    input  logic              b_rd_en,
    input  logic [ADDR_W-1:0] b_rd_addr,
    output logic [31:0]       b_rd_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1] = DATA_INIT;

    // Port A: commit from the write pipeline, read old value + mask at accept.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_wr_addr] <= a_wr_data;
        end
        if (a_rd_en) begin
            a_rd_data <= mem[a_rd_addr];
            a_mask    <= MASK_INIT[a_rd_addr];
        end
    end

    // Port B: local read, registered.
    always_ff @(posedge clk) begin
        if (b_rd_en) begin
            b_rd_data <= mem[b_rd_addr];
        end
    end

endmodule

// File: rtl/pcileech_cfgshadow_rsp.sv
// Config-space shadow responder. Local DWORD reads return one clock after the
// sampling edge; host writes pass a 3-stage read-modify-write pipeline
// (accept, merge, commit) with forwarding so back-to-back writes and reads
// always see the newest value.
// Optional feature macro: CFGSHADOW_MSIX_SNOOP_EN (MSI-X Enable / Function
// Mask snooped from commits to the MSI-X cap header DWORD).
module pcileech_cfgshadow_rsp #(
    parameter int ADDR_W = pcileech_cfgshadow_pkg::CFG_ADDR_W,
    parameter pcileech_cfgshadow_pkg::cfg_ram_t DATA_INIT = pcileech_cfgshadow_pkg::CFG_DATA_IMG,
    parameter pcileech_cfgshadow_pkg::cfg_ram_t MASK_INIT = pcileech_cfgshadow_pkg::CFG_MASK_IMG,
    parameter logic [ADDR_W-1:0] MSIX_CAP_DW = pcileech_cfgshadow_pkg::MSIX_CAP_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_rden,
    input  logic [ADDR_W-1:0] cfg_rd_addr,
    output logic [31:0]       cfg_rd_data,
    output logic              cfg_rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    output logic              msix_enable,
    output logic              msix_fnmask
);

    import pcileech_cfgshadow_pkg::*;

    function automatic logic [31:0] merge_dw(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    logic              accept;
    logic              commit_we;

    logic              vld_p0, vld_p1, vld_p2;
    logic [ADDR_W-1:0] addr_p0, addr_p1, addr_p2;
    logic [3:0]        be_p0;
    logic [31:0]       wdata_p0;
    logic [31:0]       data_p1, data_p2;
    logic [31:0]       ram_a_q, mask_q;
    logic [31:0]       old_p0, merged_p0;

    logic              rd_vld_p0;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic [31:0]       ram_b_q;
    logic [31:0]       rd_fwd;

    assign accept    = wr_valid & wr_ready;
    assign commit_we = vld_p1 & ~rst;

    pcileech_cfgshadow_ram #(
        .ADDR_W    (ADDR_W),
        .DATA_INIT (DATA_INIT),
        .MASK_INIT (MASK_INIT)
    ) u_ram (
        .clk       (clk),
        .a_rd_en   (accept),
        .a_rd_addr (wr_addr),
        .a_rd_data (ram_a_q),
        .a_mask    (mask_q),
        .a_we      (commit_we),
        .a_wr_addr (addr_p1),
        .a_wr_data (data_p1),
        .b_rd_en   (cfg_rden),
        .b_rd_addr (cfg_rd_addr),
        .b_rd_data (ram_b_q)
    );

    // W1 merge: pick the newest old value (pending commit, then the commit
    // the RAM read just missed, then RAM) and apply the masked byte lanes.
    always_comb begin
        old_p0 = ram_a_q;
        if (vld_p2 && (addr_p2 == addr_p0)) old_p0 = data_p2;
        if (vld_p1 && (addr_p1 == addr_p0)) old_p0 = data_p1;
        merged_p0 = merge_dw(old_p0, wdata_p0, mask_q & be_to_mask(be_p0));
    end

    // Local read resolve: writes still in flight when the read was sampled
    // sit in p1/p2 by now and override the RAM output.
    always_comb begin
        rd_fwd = ram_b_q;
        if (vld_p2 && (addr_p2 == rd_addr_p0)) rd_fwd = data_p2;
        if (vld_p1 && (addr_p1 == rd_addr_p0)) rd_fwd = data_p1;
    end

    // Control: valids, ready and read outputs; rst flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ready     <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            rd_vld_p0    <= 1'b0;
            cfg_rd_valid <= 1'b0;
            cfg_rd_data  <= '0;
        end else begin
            wr_ready     <= 1'b1;
            vld_p0       <= accept;
            vld_p1       <= vld_p0;
            vld_p2       <= vld_p1;
            rd_vld_p0    <= cfg_rden;
            cfg_rd_valid <= rd_vld_p0;
            if (rd_vld_p0) begin
                cfg_rd_data <= rd_fwd;
            end
        end
    end

    // Datapath stage registers (no reset; qualified by the valids).
    always_ff @(posedge clk) begin
        // ---- W0 accept ----
        if (accept) begin
            addr_p0  <= wr_addr;
            be_p0    <= wr_be;
            wdata_p0 <= wr_data;
        end
        // ---- W1 -> W2 ----
        addr_p1    <= addr_p0;
        data_p1    <= merged_p0;
        // ---- W2 commit, kept one cycle for forwarding ----
        addr_p2    <= addr_p1;
        data_p2    <= data_p1;
        // ---- local read address ----
        rd_addr_p0 <= cfg_rd_addr;
    end

`ifdef CFGSHADOW_MSIX_SNOOP_EN
    // Snoop MSI-X MsgCtrl Enable / Function Mask at the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            msix_enable <= 1'b0;
            msix_fnmask <= 1'b0;
        end else if (vld_p1 && (addr_p1 == MSIX_CAP_DW)) begin
            msix_enable <= data_p1[MSIX_EN_BIT];
            msix_fnmask <= data_p1[MSIX_FNMASK_BIT];
        end
    end
`else
    assign msix_enable = 1'b0;
    assign msix_fnmask = 1'b0;
`endif

endmodule

// File: tb/tb_pcileech_cfgshadow_rsp.sv
// Directed bench for pcileech_cfgshadow_rsp using the default power-up images.
// Inputs change and outputs are sampled on the falling edge.
module tb_pcileech_cfgshadow_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_rden;
    logic [9:0]  cfg_rd_addr;
    logic [31:0] cfg_rd_data;
    logic        cfg_rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        msix_enable;
    logic        msix_fnmask;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CFGSHADOW_MSIX_SNOOP_EN
    localparam logic SNOOP = 1'b1;
`else
    localparam logic SNOOP = 1'b0;
`endif

    pcileech_cfgshadow_rsp dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_rden     (cfg_rden),
        .cfg_rd_addr  (cfg_rd_addr),
        .cfg_rd_data  (cfg_rd_data),
        .cfg_rd_valid (cfg_rd_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_be        (wr_be),
        .wr_data      (wr_data),
        .msix_enable  (msix_enable),
        .msix_fnmask  (msix_fnmask)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One write beat: accepted on the next rising edge, returns one negedge later.
    task automatic wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_be    = be;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Read sampled at edge k, checked after edge k+1.
    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
        cfg_rden    = 1'b1;
        cfg_rd_addr = a;
        @(negedge clk);
        cfg_rden = 1'b0;
        @(negedge clk);
        check_eq({tag, "_valid"}, {31'b0, cfg_rd_valid}, 32'd1);
        check_eq({tag, "_data"}, cfg_rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; cfg_rden = 1'b0; cfg_rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;

        // Reset state
        cyc(3);
        check_eq("rst_rd_data", cfg_rd_data, 32'h0);
        check_eq("rst_rd_valid", {31'b0, cfg_rd_valid}, 32'd0);
        check_eq("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        check_eq("rst_msix_en", {31'b0, msix_enable}, 32'd0);
        check_eq("rst_msix_fm", {31'b0, msix_fnmask}, 32'd0);
        rst = 1'b0;
        cyc(2);
        check_eq("wr_ready_up", {31'b0, wr_ready}, 32'd1);

        // 1: plain reads of initial contents, data held afterwards
        rd("init0", 10'h000, 32'h0666_10EE);
        cyc(1);
        check_eq("valid_pulse", {31'b0, cfg_rd_valid}, 32'd0);
        check_eq("data_held", cfg_rd_data, 32'h0666_10EE);
        rd("init20", 10'h020, 32'hA5A5_0000);

        // Back-to-back reads
        cfg_rden = 1'b1; cfg_rd_addr = 10'h000;
        @(negedge clk);
        cfg_rd_addr = 10'h030;
        @(negedge clk);
        cfg_rden = 1'b0;
        check_eq("b2b_first", cfg_rd_data, 32'h0666_10EE);
        @(negedge clk);
        check_eq("b2b_second", cfg_rd_data, 32'h1111_2222);

        // 2: writemask limits a full write to bits 31:30
        wr(10'h010, 4'hF, 32'hFFFF_FFFF);
        cyc(3);
        rd("mask_full", 10'h010, 32'hC003_7011);

        // 3: consecutive writes to the same DWORD merge through forwarding
        wr(10'h010, 4'h8, 32'h8000_0000);
        wr(10'h010, 4'h8, 32'h4000_0000);
        cyc(3);
        rd("fwd_b2b", 10'h010, 32'h4003_7011);
        check_eq("msix_en_after3", {31'b0, msix_enable}, 32'd0);
        check_eq("msix_fm_after3", {31'b0, msix_fnmask}, {31'b0, SNOOP});

        // Partial byte enables, be=0, and writes one idle cycle apart
        wr(10'h030, 4'h3, 32'hFFFF_FFFF);
        cyc(3);
        rd("be_low", 10'h030, 32'h1111_FFFF);
        wr(10'h030, 4'h0, 32'h0000_0000);
        cyc(3);
        rd("be_zero", 10'h030, 32'h1111_FFFF);
        wr(10'h030, 4'h1, 32'h0000_0000);
        cyc(1);
        wr(10'h030, 4'h2, 32'h0000_0000);
        cyc(3);
        rd("fwd_gap", 10'h030, 32'h1111_0000);

        // 4: read one cycle after write accept returns the new value
        wr(10'h020, 4'hF, 32'h1234_5678);
        rd("rd_collide", 10'h020, 32'h1234_5678);

        // 5: reset right after accept drops the write
        cyc(2);
        wr(10'h020, 4'hF, 32'hCAFE_F00D);
        rst = 1'b1;
        cyc(1);
        check_eq("rst5_rd_valid", {31'b0, cfg_rd_valid}, 32'd0);
        check_eq("rst5_rd_data", cfg_rd_data, 32'h0);
        check_eq("rst5_wr_ready", {31'b0, wr_ready}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        check_eq("rst5_msix_fm", {31'b0, msix_fnmask}, 32'd0);
        rd("rst_drop", 10'h020, 32'h1234_5678);

        // 6: MSI-X enable snoop at the commit edge
        wr(10'h010, 4'h8, 32'h8000_0000);
        cyc(1);
        check_eq("msix_before", {31'b0, msix_enable}, 32'd0);
        cyc(1);
        check_eq("msix_commit", {31'b0, msix_enable}, {31'b0, SNOOP});
        check_eq("msix_fm_clr", {31'b0, msix_fnmask}, 32'd0);
        rd("msix_dw", 10'h010, 32'h8003_7011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
